fc_layer_sequencer: RTL and testbench



---
 rtl/fc_pkg.sv | 16 +
 rtl/fc_mac.sv | 30 +++
 rtl/relu.sv | 12 +
 rtl/fc_layer_sequencer.sv | 152 +++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared state encoding and accumulator sizing for the FC layer sequencer
package fc_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_MAC,
    S_FLUSH,
    S_OUT
  } state_t;

  // Room for fan_in worst-case products of two width-bit signed operands.
  function automatic int width_acc(input int width, input int fan_in);
    return 2 * width + $clog2(fan_in);
  endfunction

endpackage

// File: rtl/fc_mac.sv
// rtl/fc_mac.sv - signed multiply-accumulate with synchronous clear and enable
module fc_mac #(
  parameter int WIDTH = 8,
  parameter int AW    = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic            clr,
  input  logic            en,
  output logic [AW-1:0]   acc
);

  logic signed [2*WIDTH-1:0] prod;

  assign prod = $signed(a) * $signed(b);

  // Signed size cast sign-extends the full product to the accumulator width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + AW'(prod);
    end
  end

endmodule

// File: rtl/relu.sv
// rtl/relu.sv - signed max(a, b); with b tied to zero it is a ReLU
module relu #(
  parameter int W = 18
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = ($signed(a) > $signed(b)) ? a : b;

endmodule

// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - buffers one input vector and evaluates OUT neurons on a single MAC
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int OUT   = 10,
  localparam int AW   = width_acc(WIDTH, IN),
  localparam int WA   = $clog2(IN * OUT),
  localparam int NW   = $clog2(OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WA-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_data,
  output logic [NW-1:0]    out_idx,
  output logic             busy
);

  localparam int IW = $clog2(IN);
  localparam logic [IW-1:0] I_LAST = IW'(IN - 1);
  localparam logic [NW-1:0] N_LAST = NW'(OUT - 1);

  state_t           state, state_next;
  logic [IW-1:0]    k, i;
  logic [NW-1:0]    n;
  logic [WIDTH-1:0] x [IN];
  logic [WIDTH-1:0] x_op;
  logic             mac_clr, mac_en;
  logic [AW-1:0]    acc;
  logic             beat;

  assign beat = (state == S_LOAD) && in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LOAD;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == S_LOAD);
    end
  end

  // w_data arrives one cycle after its address, so MAC pairs it with x[i-1].
  always_comb begin
    state_next = state;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    x_op       = x[I_LAST];
    case (state)
      S_LOAD: begin
        if (beat && k == I_LAST) begin
          state_next = S_MAC;
          mac_clr    = 1'b1;
        end
      end
      S_MAC: begin
        mac_en = (i != '0);
        x_op   = x[i - 1'b1];
        if (i == I_LAST) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        mac_en     = 1'b1;
        state_next = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (n == N_LAST) begin
            state_next = S_LOAD;
          end else begin
            state_next = S_MAC;
            mac_clr    = 1'b1;
          end
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
      i <= '0;
      n <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (beat) begin
            if (k == I_LAST) begin
              k <= '0;
              i <= '0;
              n <= '0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        S_MAC: i <= (i == I_LAST) ? '0 : i + 1'b1;
        S_OUT: begin
          if (out_ready) begin
            if (n == N_LAST) begin
              k <= '0;
            end else begin
              n <= n + 1'b1;
              i <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The activation buffer survives reset; only a new LOAD overwrites it.
  always_ff @(posedge clk) begin
    if (beat) x[k] <= in_data;
  end

  fc_mac #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (x_op),
    .b    (w_data),
    .clr  (mac_clr),
    .en   (mac_en),
    .acc  (acc)
  );

  relu #(
    .W(AW)
  ) u_relu (
    .a(acc),
    .b({AW{1'b0}}),
    .y(out_data)
  );

  assign w_addr    = (state == S_MAC) ? WA'(n) * WA'(IN) + WA'(i) : '0;
  assign out_valid = (state == S_OUT);
  assign out_idx   = n;
  assign busy      = (state != S_LOAD);

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb/tb_fc_layer_sequencer.sv - directed self-checking bench for fc_layer_sequencer (IN=4, OUT=2, WIDTH=8)
module tb_fc_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [2:0]  w_addr;
  logic [7:0]  w_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] out_data;
  logic [0:0]  out_idx;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_last = 0;

  logic signed [7:0] rom [8];
  logic signed [7:0] xv [4];

  fc_layer_sequencer #(
    .WIDTH(8),
    .IN   (4),
    .OUT  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    w_data <= rom[w_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_vec(input bit rnd);
    int b = 0;
    int guard = 0;
    while (b < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = xv[b];
      if (in_valid && in_ready) begin
        if (b == 3) t_last = cyc;
        b++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("load_beats", b, 4);
  endtask

  // Entered just after the capture or previous handshake edge.
  task automatic collect(input int idx, input int exp, input int hold, input bit junk);
    int waited = 0;
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'd99;
    end
    out_ready = (hold == 0);
    while (!out_valid && waited < 40) begin
      if (waited < 4) chk("w_addr_mac", w_addr, idx * 4 + waited);
      else chk("w_addr_flush", w_addr, 0);
      @(negedge clk);
      waited++;
    end
    in_valid = 1'b0;
    chk("out_valid", out_valid, 1);
    chk("latency", waited, 5);
    if (idx == 0) chk("first_valid_cycle", cyc, t_last + 6);
    chk("out_idx", out_idx, idx);
    chk("out_data", out_data, exp);
    chk("busy_out", busy, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, exp);
      chk("hold_idx", out_idx, idx);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_w_addr", w_addr, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, (idx == 1));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_w_addr", w_addr, 0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 0);
    @(negedge clk);
    chk("first_edge_in_ready", in_ready, 1);
    chk("first_edge_busy", busy, 0);

    // Basic vector, idx0 positive, idx1 clamped by ReLU
    rom = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd1};
    xv  = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    load_vec(1'b0);
    collect(0, 10, 0, 1'b0);
    collect(1, 0, 0, 1'b0);

    // Worst-case magnitude products
    rom = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128};
    xv  = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
    load_vec(1'b0);
    collect(0, 65536, 0, 1'b0);
    collect(1, 65536, 0, 1'b0);

    // Backpressure in OUT
    rom = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd0, 8'sd0, 8'sd0, 8'sd5};
    xv  = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    load_vec(1'b0);
    collect(0, 30, 5, 1'b0);
    collect(1, 20, 0, 1'b0);

    // Reset at MAC i=2, then a fresh vector
    load_vec(1'b0);
    for (int g = 0; g < 10 && w_addr != 3'd2; g++) @(negedge clk);
    chk("abort_at_i2", w_addr, 2);
    rst_n = 1'b0;
    #1;
    chk("abort_w_addr", w_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_out_idx", out_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rom = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd2, 8'sd3, 8'sd4};
    xv  = '{8'sd5, -8'sd3, 8'sd2, 8'sd1};
    load_vec(1'b0);
    collect(0, 5, 0, 1'b0);
    collect(1, 9, 0, 1'b0);

    // Random in_valid in LOAD, stray in_valid during MAC
    rom = '{8'sd3, -8'sd1, 8'sd2, 8'sd4, -8'sd4, 8'sd2, 8'sd1, -8'sd3};
    xv  = '{-8'sd2, 8'sd7, -8'sd5, 8'sd3};
    load_vec(1'b1);
    collect(0, 0, 0, 1'b1);
    collect(1, 8, 0, 1'b1);

    // Back-to-back vectors with out_ready high
    rom = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd2, 8'sd2, 8'sd2, 8'sd2};
    xv  = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    load_vec(1'b0);
    collect(0, 30, 0, 1'b0);
    collect(1, 20, 0, 1'b0);
    xv  = '{8'sd4, 8'sd3, 8'sd2, 8'sd1};
    load_vec(1'b0);
    collect(0, 20, 0, 1'b0);
    collect(1, 20, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
